// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration-time helpers, used by uart_tx and
// by the transmit arbiter that feeds it.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_START_BITS = 1;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2, never less than 1 so that index ports always exist.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // Clock cycles per bit; integer division, matching uart_tx.
    function automatic int bit_cycles(input int freq, input int rate);
        return freq / rate;
    endfunction

    // Clock cycles for a whole frame: start bit, data bits, stop bits.
    function automatic int frame_cycles(input int freq, input int rate, input int stop_bits);
        return bit_cycles(freq, rate) * (UART_START_BITS + UART_DATA_BITS + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and uart_tx-side signals of the transmit arbiter.
// The arbiter uses the slave modport; the requester/top side uses master.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int GW = clog2(N_REQ);

    logic [N_REQ-1:0]   req_vld;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_rdy;
    logic [7:0]         tx_data;
    logic               tx_vld;
    logic [GW-1:0]      grant_id;
    logic               busy;

    modport master (
        output req_vld,
        output req_data,
        input  req_rdy,
        input  tx_data,
        input  tx_vld,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  req_vld,
        input  req_data,
        output req_rdy,
        output tx_data,
        output tx_vld,
        output grant_id,
        output busy
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: picks the first set request after
// 'last', wrapping around. Generic enough for any shared-resource arbiter.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the farthest offset back to the nearest so the nearest
    // requester after 'last' overwrites and therefore wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                any = 1'b1;
                idx = W'((int'(last) + k) % N);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign onehot[gi] = any && (idx == W'(gi));
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// uart_tx has no busy flag, so the frame is timed here and no byte is
// launched until the previous frame plus one guard cycle has elapsed.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FREQ      = 50_000_000,
    parameter int RATE      = 2_000_000,
    parameter int STOP_BITS = 1
) (
    input logic         CLK,
    input logic         rst_n,
    uart_tx_arb_if.slave bus
);

    localparam int BIT_CYC   = bit_cycles(FREQ, RATE);
    localparam int FRAME_CYC = frame_cycles(FREQ, RATE, STOP_BITS);
    localparam int CNT_W     = clog2(FRAME_CYC);
    localparam int GW        = clog2(N_REQ);

    if (BIT_CYC < 2) begin : g_bad_rate
        $error("uart_tx_arb: FREQ/RATE must be at least 2");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("uart_tx_arb: N_REQ must be in 2..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_arb: STOP_BITS must be 1 or 2");
    end

    arb_state_t       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             tx_vld_reg,  tx_vld_next;
    logic [GW-1:0]    grant_reg,   grant_next;
    logic [GW-1:0]    last_reg,    last_next;
    logic [N_REQ-1:0] rdy_comb;

    logic [N_REQ-1:0] pick_onehot;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;
    logic [7:0]       req_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = bus.req_data[8*gi +: 8];
    end

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req    (bus.req_vld),
        .last   (last_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // State and output registers; reset clears everything at once and
    // points 'last' at the top index so requester 0 is favoured first.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            tx_data_reg <= '0;
            tx_vld_reg  <= 1'b0;
            grant_reg   <= '0;
            last_reg    <= GW'(N_REQ - 1);
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            tx_data_reg <= tx_data_next;
            tx_vld_reg  <= tx_vld_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
        end
    end

    // Next-state logic: accept the round-robin winner in IDLE, then count
    // the frame down in BUSY with all requesters held off.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        tx_data_next = tx_data_reg;
        tx_vld_next  = 1'b0;
        grant_next   = grant_reg;
        last_next    = last_reg;
        rdy_comb     = '0;
        case (state_reg)
            IDLE: begin
                rdy_comb = pick_onehot;
                if (pick_any) begin
                    tx_data_next = req_bytes[pick_idx];
                    tx_vld_next  = 1'b1;
                    grant_next   = pick_idx;
                    last_next    = pick_idx;
                    cnt_next     = CNT_W'(FRAME_CYC - 1);
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.req_rdy  = rdy_comb;
    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_vld   = tx_vld_reg;
    assign bus.grant_id = grant_reg;
    assign bus.busy     = (state_reg == BUSY);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: the stimulus process predicts each
// launch from the round-robin and frame-time rules and queues it; a
// monitor pops and compares whenever tx_vld is seen.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int N   = 4;
    localparam int PER = 10;
    localparam int FRAME = 250;   // 25 cycles/bit * 10 bits

    logic CLK = 1'b0;
    logic rst_n;
    always #(PER/2) CLK = ~CLK;

    uart_tx_arb_if #(.N_REQ(N)) bus ();
    uart_tx_arb_if #(.N_REQ(2)) bus2 ();

    uart_tx_arb #(
        .N_REQ(N), .FREQ(50_000_000), .RATE(2_000_000), .STOP_BITS(1)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .bus(bus.slave)
    );

    uart_tx_arb #(
        .N_REQ(2), .FREQ(50_000_000), .RATE(115_200), .STOP_BITS(2)
    ) dut2 (
        .CLK(CLK), .rst_n(rst_n), .bus(bus2.slave)
    );

    typedef struct {
        logic [7:0] data;
        int         id;
        int         t;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int         cyc;
    int         free_cyc;
    int         m_last;
    int         granted;
    bit [N-1:0] vld_r;
    logic [7:0] dat_r [N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (vld_r[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_data[8*i +: 8] = dat_r[i];
        end
        bus.req_vld = vld_r;
    endtask

    // One clock cycle, entered and left at a falling edge.
    // mode 0: random traffic with occasional withdrawals
    // mode 1: every requester always valid with byte 8'h30+i
    // mode 2: requesters keep their current request until granted
    task automatic step(input int mode);
        int t0;
        int w;
        t0 = int'($time);
        check("busy", int'(bus.busy), (cyc < free_cyc) ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0: begin
                    if (vld_r[i]) begin
                        if (granted == i) begin
                            if ($urandom_range(3) == 0) dat_r[i] = 8'($urandom);
                            else vld_r[i] = 1'b0;
                        end else if ($urandom_range(399) == 0) begin
                            vld_r[i] = 1'b0;
                        end
                    end else if ($urandom_range(7) == 0) begin
                        vld_r[i] = 1'b1;
                        dat_r[i] = 8'($urandom);
                    end
                end
                1: begin
                    vld_r[i] = 1'b1;
                    dat_r[i] = 8'(8'h30 + i);
                end
                default: begin
                    if (vld_r[i] && granted == i) vld_r[i] = 1'b0;
                end
            endcase
        end
        granted = -1;
        drive();
        #1;
        w = (cyc >= free_cyc) ? model_winner() : -1;
        check("req_rdy", int'(bus.req_rdy), (w >= 0) ? (1 << w) : 0);
        if (w >= 0) begin
            sb_q.push_back('{data: dat_r[w], id: w, t: t0 + PER});
            free_cyc = cyc + FRAME + 1;
            m_last   = w;
            granted  = w;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic model_clear();
        sb_q.delete();
        cyc      = 0;
        free_cyc = 0;
        m_last   = N - 1;
        granted  = -1;
        vld_r    = '0;
        for (int i = 0; i < N; i++) dat_r[i] = 8'h00;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge CLK);
        check("rst_tx_vld", int'(bus.tx_vld), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        check("rst_grant_id", int'(bus.grant_id), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_req_rdy", int'(bus.req_rdy), 0);
        rst_n = 1'b1;
    endtask

    // Monitor: every tx_vld pulse must match the oldest prediction, at
    // exactly the predicted time; overdue predictions are missed launches.
    always @(negedge CLK) begin
        if (rst_n) begin
            while (sb_q.size() > 0 && sb_q[0].t < int'($time)) begin
                check("tx_vld_missing", 0, 1);
                void'(sb_q.pop_front());
            end
            if (bus.tx_vld) begin
                if (sb_q.size() == 0) begin
                    check("tx_vld_stray", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("tx_time", int'($time), e.t);
                    check("tx_data", int'(bus.tx_data), int'(e.data));
                    check("grant_id", int'(bus.grant_id), e.id);
                    $display("launch id=%0d data=%02h t=%0t", bus.grant_id, bus.tx_data, $time);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus2.req_vld  = '0;
        bus2.req_data = '0;
        model_clear();
        repeat (3) @(negedge CLK);
        do_reset();

        // Single requester 2 with 8'h41
        vld_r[2] = 1'b1;
        dat_r[2] = 8'h41;
        repeat (FRAME + 10) step(2);

        // All requesters always valid: rotation 0,1,2,3,0
        do_reset();
        repeat (5 * (FRAME + 1) + 5) step(1);

        // Random traffic
        do_reset();
        repeat (8000) step(0);
        vld_r = '0;
        repeat (FRAME + 10) step(2);

        // Reset about 100 cycles into a frame owned by requester 3
        vld_r[3] = 1'b1;
        dat_r[3] = 8'hA5;
        repeat (101) step(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_vld", int'(bus.tx_vld), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_grant_id", int'(bus.grant_id), 0);
        check("midrst_tx_data", int'(bus.tx_data), 0);
        model_clear();
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        vld_r[0] = 1'b1;
        dat_r[0] = 8'h10;
        vld_r[2] = 1'b1;
        dat_r[2] = 8'h12;
        repeat (2 * (FRAME + 1) + 10) step(2);

        // Slow rate, two stop bits: 434 cycles/bit * 11 bits = 4774
        @(negedge CLK);
        bus2.req_vld  = 2'b01;
        bus2.req_data = 16'h0055;
        #1;
        check("slow_req_rdy", int'(bus2.req_rdy), 1);
        @(negedge CLK);
        bus2.req_vld = 2'b00;
        check("slow_tx_vld", int'(bus2.tx_vld), 1);
        check("slow_tx_data", int'(bus2.tx_data), 8'h55);
        n = 0;
        while (bus2.busy && n < 10000) begin
            n++;
            @(negedge CLK);
        end
        check("slow_busy_cycles", n, 4774);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
